// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state encoding and line constants for the FIFO-drain UART transmitter
package fifo_uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter; bit_end marks the last clock of each UART bit
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Held at zero outside timed states so each bit period starts aligned to its state entry.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the upstream FIFO and sends them as 8N1 UART frames, LSB first.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       bit_end;
  logic       timer_clear;
`ifdef FIFO_UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign timer_clear = (state_q == S_IDLE) || (state_q == S_REQ) || (state_q == S_LOAD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    fifo_rd_en = 1'b0;
    tx         = IDLE_LVL;
    busy       = (state_q != S_IDLE);
    tx_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_REQ;
      end
      S_REQ: begin
        fifo_rd_en = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        shift_d   = fifo_data;
        bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = ^fifo_data;
`endif
        state_d   = S_START;
      end
      S_START: begin
        tx = START_LVL;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx = shift_q[0];
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        tx = parity_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        tx_done = bit_end;
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - bench for fifo_uart_tx with a queue-based FIFO and frame-level expectation model
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int SEL_TX   = 0;
  localparam int SEL_RD   = 1;
  localparam int SEL_DONE = 2;
  localparam int SEL_BUSY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_sched = 0;
  logic [7:0] fifo_q[$];
  logic [3:0] exp_q[$];
  logic [7:0] pending = 8'h00;
  logic       load_next = 1'b0;
  logic       tx_log   [0:1023];
  logic       rd_log   [0:1023];
  logic       done_log [0:1023];
  logic       busy_log [0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Expected {tx, rd_en, busy, tx_done} for every cycle from REQ through the stop bit.
  task automatic build_frame(input logic [7:0] b);
    logic lvl;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1010);
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0)              lvl = 1'b0;
      else if (k <= 8)         lvl = b[k-1];
      else if (k == NBITS - 1) lvl = 1'b1;
      else                     lvl = ^b;
      for (int j = 0; j < CPB; j++)
        exp_q.push_back({lvl, 1'b0, 1'b1, ((k == NBITS - 1) && (j == CPB - 1))});
    end
  endtask

  task automatic cycle();
    logic [3:0] exp;
    logic [3:0] act;
    logic       idle_now;
    @(negedge clk);
    cyc++;
    act = {tx, fifo_rd_en, busy, tx_done};
    tx_log[cyc]   = tx;
    rd_log[cyc]   = fifo_rd_en;
    done_log[cyc] = tx_done;
    busy_log[cyc] = busy;
    idle_now = 1'b0;
    if (!rst) begin
      exp_q.delete();
      load_next = 1'b0;
      exp = 4'b1000;
    end else if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
    end else begin
      exp = 4'b1000;
      idle_now = 1'b1;
    end
    chk("cycle", 32'(act), 32'(exp));
    if (fifo_rd_en === 1'b1) begin
      if (fifo_q.size() > 0) pending = fifo_q.pop_front();
      else                   pending = 8'hEE;
      fifo_data = ~pending;
      load_next = 1'b1;
    end else if (load_next) begin
      fifo_data = pending;
      load_next = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
    if (idle_now && !fifo_empty) begin
      build_frame(fifo_q[0]);
      last_sched = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  function automatic int cnt(input int sel, input int a, input int b);
    int s;
    s = 0;
    for (int i = a; i <= b; i++) begin
      case (sel)
        SEL_TX:   s += int'(tx_log[i]);
        SEL_RD:   s += int'(rd_log[i]);
        SEL_DONE: s += int'(done_log[i]);
        default:  s += int'(busy_log[i]);
      endcase
    end
    return s;
  endfunction

  initial begin
    int         n;
    logic [3:0] s;
    logic [10:0] pat_a5;
`ifdef FIFO_UART_TX_PARITY_EN
    pat_a5 = 11'b10101001010;
`else
    pat_a5 = 11'b01101001010;
`endif
    rst        = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    #1;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    run(3);
    rst = 1'b1;
    run(2);

    // Single byte 0xA5
    fifo_q.push_back(8'hA5);
    cycle();
    n = last_sched;
    run(49);
    chk("a5_rd_at_n1", 32'(rd_log[n+1]), 32'd1);
    chk("a5_rd_count", 32'(cnt(SEL_RD, n, n + 49)), 32'd1);
    chk("a5_pre_start_high", 32'(tx_log[n+2]), 32'd1);
    for (int k = 0; k < NBITS; k++) begin
      for (int j = 0; j < CPB; j++) s[j] = tx_log[n + 3 + CPB*k + j];
      chk($sformatf("a5_level%0d", k), 32'(s), 32'({4{pat_a5[k]}}));
    end
    chk("a5_done_at", 32'(done_log[n + 2 + CPB*NBITS]), 32'd1);
    chk("a5_done_count", 32'(cnt(SEL_DONE, n, n + 49)), 32'd1);
    chk("a5_busy_last", 32'(busy_log[n + 2 + CPB*NBITS]), 32'd1);
    chk("a5_busy_after", 32'(busy_log[n + 3 + CPB*NBITS]), 32'd0);

    // Back-to-back 0x00, 0xFF
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    cycle();
    n = last_sched;
    run(2*(CPB*NBITS + 3) + 10);
    chk("b2b_rd_count", 32'(cnt(SEL_RD, n, n + 2*(CPB*NBITS + 3) + 10)), 32'd2);
    chk("b2b_rd_second", 32'(rd_log[n + 1 + CPB*NBITS + 3]), 32'd1);
    chk("b2b_gap_high", 32'(cnt(SEL_TX, n + CPB*NBITS + 3, n + CPB*NBITS + 5)), 32'd3);
    chk("b2b_gap_idle", 32'(busy_log[n + CPB*NBITS + 3]), 32'd0);
    chk("b2b_second_start", 32'(tx_log[n + CPB*NBITS + 6]), 32'd0);
    chk("b2b_first_zeros", 32'(cnt(SEL_TX, n + 7, n + 38)), 32'd0);
    chk("b2b_second_ones", 32'(cnt(SEL_TX, n + CPB*NBITS + 10, n + CPB*NBITS + 41)), 32'd32);

    // FIFO empty for 100 cycles
    n = cyc;
    run(100);
    chk("empty_rd", 32'(cnt(SEL_RD, n + 1, n + 100)), 32'd0);
    chk("empty_busy", 32'(cnt(SEL_BUSY, n + 1, n + 100)), 32'd0);
    chk("empty_tx", 32'(cnt(SEL_TX, n + 1, n + 100)), 32'd100);

    // Reset during data bit 4 of 0x3C
    fifo_q.push_back(8'h3C);
    cycle();
    n = last_sched;
    run(24);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rd", 32'(fifo_rd_en), 32'd0);
    chk("mid_rst_done", 32'(tx_done), 32'd0);
    run(3);
    rst = 1'b1;
    n = cyc;
    run(30);
    chk("post_rst_rd", 32'(cnt(SEL_RD, n + 1, n + 30)), 32'd0);
    chk("post_rst_tx", 32'(cnt(SEL_TX, n + 1, n + 30)), 32'd30);

    // Byte 0x07: even parity 1 when compiled in
    fifo_q.push_back(8'h07);
    cycle();
    n = last_sched;
    run(CPB*NBITS + 6);
    chk("b07_start", 32'(tx_log[n+3]), 32'd0);
    chk("b07_low_bits", 32'(cnt(SEL_TX, n + 7, n + 18)), 32'd12);
    chk("b07_high_bits", 32'(cnt(SEL_TX, n + 19, n + 38)), 32'd0);
    chk("b07_done_at", 32'(done_log[n + 2 + CPB*NBITS]), 32'd1);
`ifdef FIFO_UART_TX_PARITY_EN
    chk("b07_parity", 32'(cnt(SEL_TX, n + 39, n + 42)), 32'd4);
    chk("b07_frame_len", 32'(done_log[n + 46]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drain stage that sits directly downstream of the 64-entry byte FIFO.
- Pops one byte at a time through the FIFO's read port and serializes it onto an 8N1 UART line, LSB first.
- Holds off further reads until the current frame's stop bit completes.
- Single clock domain, shared with the FIFO.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
- CNT_W, 16, width of the bit-period counter; must satisfy 2**CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk).
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO registered read data; valid the cycle after rd_en.
- fifo_rd_en  output  1  FIFO pop request, one cycle per byte.
- tx  output  1  serial line; idle high.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset values (rst low): state=IDLE, tx=1, fifo_rd_en=0, busy=0, tx_done=0, shift register=0, counters=0. Outputs take these values asynchronously the moment rst falls.
- All outputs are registered or decoded from the state register. No combinational path from any input to any output.
- FSM states: IDLE, REQ, LOAD, START, DATA, [PARITY], STOP.
- IDLE: if fifo_empty==0, go to REQ next cycle; otherwise remain in IDLE.
- REQ: exactly one cycle; fifo_rd_en=1; go to LOAD.
- LOAD: exactly one cycle; capture fifo_data into the 8-bit shift register; clear the bit counter; go to START.
- START: tx=0 for CLKS_PER_BIT cycles; then go to DATA.
- DATA:
  - tx = shift_reg[0].
  - After CLKS_PER_BIT cycles, shift right and increment the bit index.
  - After the 8th bit, go to PARITY (if compiled in) or STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 in the final cycle; then go to IDLE.
- Bit timing: the period counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on every state transition. The bit index is 3 bits and wraps 7->0 only on leaving DATA.
- Latency: fifo_empty seen low in IDLE at cycle N gives:
  - fifo_rd_en high in cycle N+1;
  - data captured at the end of N+2;
  - tx falls (start bit) in cycle N+3.
- Inter-frame gap with the FIFO non-empty: 3 cycles of tx=1 (IDLE, REQ, LOAD) after the stop bit, on top of the stop bit itself.
- Exactly one fifo_rd_en pulse per frame. fifo_rd_en is never asserted outside REQ.
- Empty boundary: REQ is entered only when fifo_empty was low, and this block is the FIFO's sole reader, so the read cannot underflow. fifo_empty changes during a frame are ignored until IDLE.
- Writes to the FIFO during a frame need no handling in this block.
- Reset mid-frame: the frame is truncated and tx returns high at once. The byte already popped is lost; no re-read is attempted.
- Frame length: 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP. It lasts CLKS_PER_BIT cycles with tx = XOR of the 8 data bits (even parity). The XOR is computed in LOAD and registered.
- Undefined: the PARITY state and its register do not exist; DATA goes directly to STOP.

Decomposition:
- Package fifo_uart_pkg:
  - state enum encoding (IDLE=0, REQ=1, LOAD=2, START=3, DATA=4, PARITY=5, STOP=6);
  - DATA_BITS=8 constant;
  - line level constants IDLE_LVL=1, START_LVL=0.
- One sub-module, uart_bit_timer:
  - parameterized by CLKS_PER_BIT;
  - inputs: clk, rst, clear;
  - output: bit_end pulse when the counter reaches CLKS_PER_BIT-1.
- The FSM and shift register stay in fifo_uart_tx.

Test Plan (CLKS_PER_BIT=4):
- Reset: rst low mid-sim -> tx=1, busy=0, fifo_rd_en=0, tx_done=0 in the same cycle, without waiting for a clock edge.
- Single byte 0xA5:
  - fifo_empty falls at cycle N -> fifo_rd_en pulses only in N+1.
  - tx = 0 | 1,0,1,0,0,1,0,1 | 1, each level held 4 cycles, starting at N+3.
  - tx_done high only in cycle N+42; busy low at N+43.
- Back-to-back 0x00 then 0xFF with the FIFO holding both:
  - exactly 2 fifo_rd_en pulses;
  - gap of 3 cycles of tx=1 between the end of the stop bit and the second start bit;
  - second frame's data bits all 1.
- FIFO stays empty 100 cycles -> fifo_rd_en never asserts, tx=1, busy=0 throughout.
- Reset mid-DATA (bit 4 of 0x3C):
  - tx=1 immediately after reset asserts.
  - After release with the FIFO empty, no further fifo_rd_en pulse and the line stays idle.
- With FIFO_UART_TX_PARITY_EN, byte 0x07 -> parity bit 1 held 4 cycles before the stop bit; frame is 44 cycles long.
